// File: rtl/conv_window_buffer_if.sv
// -----------------------------------------------------------------------------
// conv_window_buffer_if
// Pixel-stream / window bus between a raster-order pixel producer and the
// sliding-window generator.
//   clear        producer -> window : synchronous flush of the frame position
//   fifo_enable  producer -> window : fifo_data_in is accepted this cycle
//   fifo_data_in producer -> window : incoming pixel, row-major order
//   window_data  window -> consumer : packed KERNAL_SIZE x KERNAL_SIZE window
//   window_valid window -> consumer : window_data is a legal, stride-aligned window
//   out_row      window -> consumer : output-map row of the valid window
//   out_col      window -> consumer : output-map column of the valid window
//   frame_done   window -> consumer : pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
interface conv_window_buffer_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int IFM_SIZE    = 32,
  parameter int KERNAL_SIZE = 5,
  parameter int STRIDE      = 1
);
  localparam int IFM_SIZE_NEXT = (IFM_SIZE - KERNAL_SIZE) / STRIDE + 1;
  localparam int OW            = $clog2(IFM_SIZE_NEXT) + 1;
  localparam int WW            = KERNAL_SIZE * KERNAL_SIZE * DATA_WIDTH;

  logic                  clear;
  logic                  fifo_enable;
  logic [DATA_WIDTH-1:0] fifo_data_in;
  logic [WW-1:0]         window_data;
  logic                  window_valid;
  logic [OW-1:0]         out_row;
  logic [OW-1:0]         out_col;
  logic                  frame_done;

  // Pixel producer / window consumer side
  modport master (
    output clear, fifo_enable, fifo_data_in,
    input  window_data, window_valid, out_row, out_col, frame_done
  );

  // Window generator side
  modport slave (
    input  clear, fifo_enable, fifo_data_in,
    output window_data, window_valid, out_row, out_col, frame_done
  );
endinterface

// File: rtl/conv_window_buffer.sv
// -----------------------------------------------------------------------------
// conv_window_buffer
// Sliding-window generator. Keeps the last (K-1)*IFM_SIZE+K pixels of a
// raster-order stream in a shift register, exposes the K x K window as one
// packed bus and flags the cycles where that window sits on a legal,
// stride-aligned convolution position.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset (taps, counters and outputs to 0)
//   bus    conv_window_buffer_if.slave: clear / fifo_enable / fifo_data_in in,
//          window_data / window_valid / out_row / out_col / frame_done out
// -----------------------------------------------------------------------------
module conv_window_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int IFM_SIZE    = 32,
  parameter int KERNAL_SIZE = 5,
  parameter int STRIDE      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  conv_window_buffer_if.slave   bus
);

  localparam int FIFO_SIZE     = (KERNAL_SIZE - 1) * IFM_SIZE + KERNAL_SIZE;
  localparam int IFM_SIZE_NEXT = (IFM_SIZE - KERNAL_SIZE) / STRIDE + 1;
  localparam int OW            = $clog2(IFM_SIZE_NEXT) + 1;
  localparam int CW            = $clog2(IFM_SIZE) + 1;
  localparam int PW            = $clog2(STRIDE) + 1;
  localparam int WW            = KERNAL_SIZE * KERNAL_SIZE * DATA_WIDTH;

  localparam logic [CW-1:0] POS_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] POS_ONE   = CW'(1'b1);
  localparam logic [CW-1:0] POS_LAST  = CW'(IFM_SIZE - 1);
  localparam logic [CW-1:0] POS_READY = CW'(KERNAL_SIZE - 1);
  localparam logic [PW-1:0] PH_ZERO   = {PW{1'b0}};
  localparam logic [PW-1:0] PH_ONE    = PW'(1'b1);
  localparam logic [PW-1:0] PH_LAST   = PW'(STRIDE - 1);
  localparam logic [OW-1:0] OUT_ZERO  = {OW{1'b0}};
  localparam logic [OW-1:0] OUT_ONE   = OW'(1'b1);

  // Shift register; tap_q[0] holds the newest pixel
  logic [DATA_WIDTH-1:0] tap_q [FIFO_SIZE];

  // Position of the next pixel inside the frame
  logic [CW-1:0] in_row_q, in_row_d;
  logic [CW-1:0] in_col_q, in_col_d;
  // Stride phase of the current row/column, counted from position K-1
  logic [PW-1:0] row_phase_q, row_phase_d;
  logic [PW-1:0] col_phase_q, col_phase_d;
  // Output-map index the next aligned row/column will carry
  logic [OW-1:0] orow_cnt_q, orow_cnt_d;
  logic [OW-1:0] ocol_cnt_q, ocol_cnt_d;
  // Registered outputs
  logic          valid_q, valid_d;
  logic [OW-1:0] out_row_q, out_row_d;
  logic [OW-1:0] out_col_q, out_col_d;
  logic          frame_done_q, frame_done_d;

  logic          accept_s;
  logic          row_ready_s;
  logic          col_ready_s;
  logic          col_last_s;
  logic          row_last_s;
  logic [WW-1:0] window_s;

  // A pixel is taken only when no flush is requested in the same cycle
  always_comb begin
    accept_s    = bus.fifo_enable & ~bus.clear;
    row_ready_s = (in_row_q >= POS_READY);
    col_ready_s = (in_col_q >= POS_READY);
    col_last_s  = (in_col_q == POS_LAST);
    row_last_s  = (in_row_q == POS_LAST);
  end

  // Shift register: taps survive clear, only reset zeroes them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_SIZE; i++) begin
        tap_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (accept_s) begin
      tap_q[0] <= bus.fifo_data_in;
      for (int i = 1; i < FIFO_SIZE; i++) begin
        tap_q[i] <= tap_q[i-1];
      end
    end
  end

  // Window assembly: row 0 is the oldest image row, column 0 the leftmost
  always_comb begin
    window_s = {WW{1'b0}};
    for (int r = 0; r < KERNAL_SIZE; r++) begin
      for (int c = 0; c < KERNAL_SIZE; c++) begin
        window_s[(r*KERNAL_SIZE + c)*DATA_WIDTH +: DATA_WIDTH] =
          tap_q[(KERNAL_SIZE-1-r)*IFM_SIZE + (KERNAL_SIZE-1-c)];
      end
    end
  end

  // Next-state for position, stride phase and output bookkeeping
  always_comb begin
    in_row_d     = in_row_q;
    in_col_d     = in_col_q;
    row_phase_d  = row_phase_q;
    col_phase_d  = col_phase_q;
    orow_cnt_d   = orow_cnt_q;
    ocol_cnt_d   = ocol_cnt_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    valid_d      = 1'b0;
    frame_done_d = 1'b0;

    if (bus.clear) begin
      in_row_d    = POS_ZERO;
      in_col_d    = POS_ZERO;
      row_phase_d = PH_ZERO;
      col_phase_d = PH_ZERO;
      orow_cnt_d  = OUT_ZERO;
      ocol_cnt_d  = OUT_ZERO;
      out_row_d   = OUT_ZERO;
      out_col_d   = OUT_ZERO;
    end else if (bus.fifo_enable) begin
      // Window is legal when both coordinates are past K-1 and on phase 0
      if (row_ready_s && col_ready_s &&
          (row_phase_q == PH_ZERO) && (col_phase_q == PH_ZERO)) begin
        valid_d   = 1'b1;
        out_row_d = orow_cnt_q;
        out_col_d = ocol_cnt_q;
      end else begin
        valid_d   = 1'b0;
      end

      if (col_last_s) begin
        in_col_d    = POS_ZERO;
        col_phase_d = PH_ZERO;
        ocol_cnt_d  = OUT_ZERO;
        if (row_last_s) begin
          // Last pixel of the frame: everything restarts at the origin
          in_row_d     = POS_ZERO;
          row_phase_d  = PH_ZERO;
          orow_cnt_d   = OUT_ZERO;
          frame_done_d = 1'b1;
        end else begin
          in_row_d = in_row_q + POS_ONE;
          if (row_ready_s) begin
            if (row_phase_q == PH_ZERO) begin
              orow_cnt_d = orow_cnt_q + OUT_ONE;
            end else begin
              orow_cnt_d = orow_cnt_q;
            end
            row_phase_d = (row_phase_q == PH_LAST) ? PH_ZERO : (row_phase_q + PH_ONE);
          end else begin
            row_phase_d = PH_ZERO;
          end
        end
      end else begin
        in_col_d = in_col_q + POS_ONE;
        if (col_ready_s) begin
          if (col_phase_q == PH_ZERO) begin
            ocol_cnt_d = ocol_cnt_q + OUT_ONE;
          end else begin
            ocol_cnt_d = ocol_cnt_q;
          end
          col_phase_d = (col_phase_q == PH_LAST) ? PH_ZERO : (col_phase_q + PH_ONE);
        end else begin
          col_phase_d = PH_ZERO;
        end
      end
    end else begin
      // Idle cycle: pulses drop, bookkeeping holds
      valid_d      = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  // Counter and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_row_q     <= POS_ZERO;
      in_col_q     <= POS_ZERO;
      row_phase_q  <= PH_ZERO;
      col_phase_q  <= PH_ZERO;
      orow_cnt_q   <= OUT_ZERO;
      ocol_cnt_q   <= OUT_ZERO;
      out_row_q    <= OUT_ZERO;
      out_col_q    <= OUT_ZERO;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      in_row_q     <= in_row_d;
      in_col_q     <= in_col_d;
      row_phase_q  <= row_phase_d;
      col_phase_q  <= col_phase_d;
      orow_cnt_q   <= orow_cnt_d;
      ocol_cnt_q   <= ocol_cnt_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Drive the bus outputs
  assign bus.window_data  = window_s;
  assign bus.window_valid = valid_q;
  assign bus.out_row      = out_row_q;
  assign bus.out_col      = out_col_q;
  assign bus.frame_done   = frame_done_q;

endmodule

// File: tb/tb_conv_window_buffer.sv
// -----------------------------------------------------------------------------
// tb_conv_window_buffer
// Two instances (stride 1 and stride 2, 8x8 map, 3x3 kernel) fed the same
// raster stream; expected windows and flags come from frame coordinates.
// -----------------------------------------------------------------------------
module tb_conv_window_buffer;

  localparam int WW = 3 * 3 * 32;

  logic clk;
  logic reset;

  conv_window_buffer_if #(.DATA_WIDTH(32), .IFM_SIZE(8), .KERNAL_SIZE(3), .STRIDE(1)) bus1 ();
  conv_window_buffer_if #(.DATA_WIDTH(32), .IFM_SIZE(8), .KERNAL_SIZE(3), .STRIDE(2)) bus2 ();

  conv_window_buffer #(.DATA_WIDTH(32), .IFM_SIZE(8), .KERNAL_SIZE(3), .STRIDE(1)) u_dut_s1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  conv_window_buffer #(.DATA_WIDTH(32), .IFM_SIZE(8), .KERNAL_SIZE(3), .STRIDE(2)) u_dut_s2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  int          chk_cnt;
  int          pass_cnt;
  int          m_r;
  int          m_c;
  logic [31:0] m_base;
  int          n1, n2, d1, d2;

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pix(input logic [31:0] base, input int r, input int c);
    return base + 32'(r * 8 + c);
  endfunction

  function automatic logic [WW-1:0] exp_window(input logic [31:0] base, input int r, input int c);
    logic [WW-1:0] w;
    w = {WW{1'b0}};
    for (int wr = 0; wr < 3; wr++) begin
      for (int wc = 0; wc < 3; wc++) begin
        w[(wr*3 + wc)*32 +: 32] = pix(base, r - 2 + wr, c - 2 + wc);
      end
    end
    return w;
  endfunction

  // One clock: drive inputs, advance the model, check both instances
  task automatic step(input logic en, input logic clr);
    int          r;
    int          c;
    logic        ev1;
    logic        ev2;
    logic        edone;
    logic [31:0] base;
    logic [31:0] data;
    r    = m_r;
    c    = m_c;
    base = m_base;
    if (clr)     data = 32'hDEAD_BEEF;
    else if (en) data = pix(m_base, m_r, m_c);
    else         data = 32'hFFFF_FFFF;
    bus1.fifo_enable = en;  bus1.clear = clr;  bus1.fifo_data_in = data;
    bus2.fifo_enable = en;  bus2.clear = clr;  bus2.fifo_data_in = data;
    @(posedge clk);
    #1;
    ev1   = 1'b0;
    ev2   = 1'b0;
    edone = 1'b0;
    if (clr) begin
      m_r    = 0;
      m_c    = 0;
      m_base = m_base + 32'd1000;
    end else if (en) begin
      ev1   = (r >= 2) && (c >= 2);
      ev2   = ev1 && ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
      edone = (r == 7) && (c == 7);
      if (c == 7) begin
        m_c = 0;
        if (r == 7) begin
          m_r    = 0;
          m_base = m_base + 32'd1000;
        end else begin
          m_r = r + 1;
        end
      end else begin
        m_c = c + 1;
      end
    end
    chk("s1_valid", WW'(bus1.window_valid), WW'(ev1));
    chk("s1_done",  WW'(bus1.frame_done),   WW'(edone));
    chk("s2_valid", WW'(bus2.window_valid), WW'(ev2));
    chk("s2_done",  WW'(bus2.frame_done),   WW'(edone));
    if (bus1.window_valid) n1++;
    if (bus2.window_valid) n2++;
    if (bus1.frame_done)   d1++;
    if (bus2.frame_done)   d2++;
    if (ev1) begin
      chk("s1_out_row", WW'(bus1.out_row), WW'(r - 2));
      chk("s1_out_col", WW'(bus1.out_col), WW'(c - 2));
      chk("s1_window",  bus1.window_data,  exp_window(base, r, c));
    end
    if (ev2) begin
      chk("s2_out_row", WW'(bus2.out_row), WW'((r - 2) / 2));
      chk("s2_out_col", WW'(bus2.out_col), WW'((c - 2) / 2));
      chk("s2_window",  bus2.window_data,  exp_window(base, r, c));
    end
  endtask

  task automatic clear_counts();
    n1 = 0; n2 = 0; d1 = 0; d2 = 0;
  endtask

  task automatic chk_counts(input string tag, input int e1, input int e2, input int ed);
    chk({tag, "_s1_windows"}, WW'(n1), WW'(e1));
    chk({tag, "_s2_windows"}, WW'(n2), WW'(e2));
    chk({tag, "_s1_done"},    WW'(d1), WW'(ed));
    chk({tag, "_s2_done"},    WW'(d2), WW'(ed));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_s1_valid"},  WW'(bus1.window_valid), WW'(1'b0));
    chk({tag, "_s1_done"},   WW'(bus1.frame_done),   WW'(1'b0));
    chk({tag, "_s1_row"},    WW'(bus1.out_row),      WW'(1'b0));
    chk({tag, "_s1_col"},    WW'(bus1.out_col),      WW'(1'b0));
    chk({tag, "_s1_window"}, bus1.window_data,       {WW{1'b0}});
    chk({tag, "_s2_valid"},  WW'(bus2.window_valid), WW'(1'b0));
    chk({tag, "_s2_window"}, bus2.window_data,       {WW{1'b0}});
  endtask

  // Directed sequence
  initial begin
    int acc;
    chk_cnt  = 0;
    pass_cnt = 0;
    m_r = 0; m_c = 0; m_base = 32'd0;
    clear_counts();
    reset = 1'b1;
    bus1.fifo_enable = 1'b0; bus1.clear = 1'b0; bus1.fifo_data_in = 32'd0;
    bus2.fifo_enable = 1'b0; bus2.clear = 1'b0; bus2.fifo_data_in = 32'd0;

    // Reset state
    #12;
    chk_zero_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Full frame, continuous, pixel value = r*8+c
    m_base = 32'd0;
    clear_counts();
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'b0);
      if (i == 18) begin
        chk("first_elem0", WW'(bus1.window_data[0*32 +: 32]), WW'(32'd0));
        chk("first_elem4", WW'(bus1.window_data[4*32 +: 32]), WW'(32'd9));
        chk("first_elem8", WW'(bus1.window_data[8*32 +: 32]), WW'(32'd18));
        chk("first_row",   WW'(bus1.out_row), WW'(1'b0));
        chk("first_col",   WW'(bus1.out_col), WW'(1'b0));
      end
      if (i == 63) begin
        chk("last_elem8",  WW'(bus1.window_data[8*32 +: 32]), WW'(32'd63));
        chk("last_row",    WW'(bus1.out_row),      WW'(3'd5));
        chk("last_col",    WW'(bus1.out_col),      WW'(3'd5));
        chk("last_done",   WW'(bus1.frame_done),   WW'(1'b1));
        chk("s2_lastvld",  WW'(bus2.window_valid), WW'(1'b0));
        chk("s2_lastdone", WW'(bus2.frame_done),   WW'(1'b1));
      end
    end
    chk_counts("full", 36, 9, 1);

    // Gapped input at ~50% duty
    step(1'b0, 1'b0);
    clear_counts();
    acc = 0;
    for (int k = 0; k < 2000 && acc < 64; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        step(1'b1, 1'b0);
        acc++;
      end else begin
        step(1'b0, 1'b0);
      end
    end
    chk_counts("gap", 36, 9, 1);

    // Flush after 20 pixels, pixel offered during clear must be dropped
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    clear_counts();
    for (int i = 0; i < 64; i++) begin
      if (i == 18) chk("flush_early", WW'(n1), WW'(0));
      step(1'b1, 1'b0);
    end
    chk_counts("flush", 36, 9, 1);

    // Two frames back to back
    clear_counts();
    for (int i = 0; i < 128; i++) begin
      if (i == 80) chk("b2b_rows01", WW'(n1), WW'(36));
      step(1'b1, 1'b0);
    end
    chk_counts("b2b", 72, 18, 2);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_zero_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    m_r = 0; m_c = 0; m_base = 32'd9000;
    clear_counts();
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0);
    chk_counts("after_reset", 36, 9, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
